// File: rtl/soc_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Every access runs IDLE -> ACCESS -> RESP, and the granted port gets a one-cycle ack.
module soc_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  logic       prio_b;   // 1: port B wins a tie
  logic       grant_b;  // port that owns the current access
  logic       pick_b;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    pick_b = 1'b0;
    if (b_req && (!a_req || prio_b)) pick_b = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio_b   <= 1'b0;
      grant_b  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state    <= ACCESS;
            grant_b  <= pick_b;
            prio_b   <= !pick_b;
            ram_addr <= pick_b ? b_addr  : a_addr;
            ram_data <= pick_b ? b_wdata : a_wdata;
            ram_we   <= pick_b ? b_we    : a_we;
          end else begin
            ram_we <= 1'b0;
          end
        end
        ACCESS: begin
          state  <= RESP;
          ram_we <= 1'b0;
        end
        RESP: state <= IDLE;
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Reset in RESP suppresses the ack in that same cycle, so the aborted access is never reported.
  assign a_ack   = (state == RESP) && !grant_b && !rst;
  assign b_ack   = (state == RESP) &&  grant_b && !rst;
  assign a_rdata = a_ack ? ram_q : '0;
  assign b_rdata = b_ack ? ram_q : '0;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Bench for soc_ram_arbiter: per-port request drivers, a behavioural sync RAM,
// and a scoreboard of expected (port, rdata) pairs consumed on every ack.
module tb_soc_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    req_v, we_v;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wdata_v[2];
  wire           a_ack, b_ack;
  wire  [DW-1:0] a_rdata, b_rdata;
  wire  [DW-1:0] ram_data;
  wire  [AW-1:0] ram_addr;
  wire           ram_we, busy;
  logic [DW-1:0] ram_q;
  logic [1:0]    ack_v;
  logic [DW-1:0] rdata_v[2];

  assign ack_v      = {b_ack, a_ack};
  assign rdata_v[0] = a_rdata;
  assign rdata_v[1] = b_rdata;

  soc_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(req_v[0]), .a_we(we_v[0]), .a_addr(addr_v[0]), .a_wdata(wdata_v[0]),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(req_v[1]), .b_we(we_v[1]), .b_addr(addr_v[1]), .b_wdata(wdata_v[1]),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy)
  );

  // Write-first synchronous RAM; contents survive reset.
  logic [DW-1:0] mem[2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= ram_we ? ram_data : mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_ack[2];
  logic [1:0] ack_seen = 2'b00;
  logic drv_busy_a = 1'b0;
  logic drv_busy_b = 1'b0;
  txn_t txq_a[$];
  txn_t txq_b[$];
  exp_t exp_q[$];
  logic [DW-1:0] shadow[2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    last_ack[0] = 0;
    last_ack[1] = 0;
  end

  // Port A requester: holds req/we/addr/wdata from assertion until its ack.
  initial begin : drv_a
    txn_t t;
    req_v[0] = 1'b0; we_v[0] = 1'b0; addr_v[0] = '0; wdata_v[0] = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        drv_busy_a = 1'b0;
        req_v[0]   = 1'b0;
      end else begin
        if (drv_busy_a && ack_seen[0]) begin
          drv_busy_a = 1'b0;
          req_v[0]   = 1'b0;
        end
        if (!drv_busy_a && txq_a.size() > 0) begin
          t = txq_a.pop_front();
          req_v[0] = 1'b1; we_v[0] = t.we; addr_v[0] = t.addr; wdata_v[0] = t.wdata;
          drv_busy_a = 1'b1;
        end
      end
    end
  end

  initial begin : drv_b
    txn_t t;
    req_v[1] = 1'b0; we_v[1] = 1'b0; addr_v[1] = '0; wdata_v[1] = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        drv_busy_b = 1'b0;
        req_v[1]   = 1'b0;
      end else begin
        if (drv_busy_b && ack_seen[1]) begin
          drv_busy_b = 1'b0;
          req_v[1]   = 1'b0;
        end
        if (!drv_busy_b && txq_b.size() > 0) begin
          t = txq_b.pop_front();
          req_v[1] = 1'b1; we_v[1] = t.we; addr_v[1] = t.addr; wdata_v[1] = t.wdata;
          drv_busy_b = 1'b1;
        end
      end
    end
  end

  // Ack monitor: scoreboard consumption, single-ack and zero-rdata checks.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      ack_seen = ack_v;
      n_cmp++;
      if (ack_v === 2'b11) begin
        n_bad++;
        $display("FAIL both_acks cyc=%0d ack=%b required one-hot", cyc, ack_v);
      end
      for (int p = 0; p < 2; p++) begin
        if (ack_v[p] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_ack cyc=%0d port=%0d rdata=%h required no ack", cyc, p, rdata_v[p]);
          end else begin
            e = exp_q.pop_front();
            if (e.port != p || rdata_v[p] !== e.data) begin
              n_bad++;
              $display("FAIL sb_ack cyc=%0d got port=%0d rdata=%h required port=%0d rdata=%h",
                       cyc, p, rdata_v[p], e.port, e.data);
            end
          end
          last_ack[p] = cyc;
        end else begin
          n_cmp++;
          if (rdata_v[p] !== '0) begin
            n_bad++;
            $display("FAIL rdata_idle cyc=%0d port=%0d rdata=%h required 00", cyc, p, rdata_v[p]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog time=%0t required finish", $time);
    $fatal(1, "watchdog");
  end

  // Queue a transaction for a port; calls must be made in expected grant order.
  task automatic expect_txn(input int port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    txn_t t;
    exp_t e;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (we) shadow[addr] = wdata;
    e.port = port;
    e.data = shadow[addr];
    exp_q.push_back(e);
    if (port == 0) txq_a.push_back(t);
    else           txq_b.push_back(t);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && txq_a.size() == 0 && txq_b.size() == 0 &&
          !drv_busy_a && !drv_busy_b) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout pending=%0d required 0 within %0d cycles", exp_q.size(), bound);
  endtask

  // Waits for port p to raise req, then records 4 cycles: k=1 is the first cycle req is seen.
  task automatic measure(input int p, output int ack_k, output logic [4:0] we_mask,
                         output logic held_ok, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int w;
    ack_k = 0; we_mask = '0; held_ok = 1'b1;
    w = 0;
    while (req_v[p] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (ram_we === 1'b1) we_mask[k] = 1'b1;
      if (ack_v[p] === 1'b1 && ack_k == 0) ack_k = k;
      if ((k == 2 || k == 3) && (ram_addr !== addr || ram_data !== data)) held_ok = 1'b0;
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_data !== '0 || ack_v !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state busy=%b we=%b addr=%h data=%h ack=%b required all zero",
               busy, ram_we, ram_addr, ram_data, ack_v);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_we !== 1'b0 || busy !== 1'b0 || ack_v !== 2'b00) begin
        n_bad++;
        $display("FAIL idle cyc=%0d we=%b busy=%b ack=%b required 0/0/00", cyc, ram_we, busy, ack_v);
      end
    end
  endtask

  task automatic test_single_write_read;
    int ack_k;
    logic [4:0] we_mask;
    logic held_ok;
    expect_txn(0, 1'b1, 6'h05, 8'hA5);
    measure(0, ack_k, we_mask, held_ok, 6'h05, 8'hA5);
    n_cmp++;
    if (ack_k != 3 || we_mask != 5'b00100 || !held_ok) begin
      n_bad++;
      $display("FAIL write_timing ack_cycle=%0d we_mask=%b held=%b required 3/00100/1", ack_k, we_mask, held_ok);
    end
    wait_drain(20);
    expect_txn(0, 1'b0, 6'h05, 8'h00);
    measure(0, ack_k, we_mask, held_ok, 6'h05, 8'h00);
    n_cmp++;
    if (ack_k != 3 || we_mask != 5'b00000) begin
      n_bad++;
      $display("FAIL read_timing ack_cycle=%0d we_mask=%b required 3/00000", ack_k, we_mask);
    end
    wait_drain(20);
  endtask

  task automatic test_simultaneous;
    do_reset();
    expect_txn(0, 1'b1, 6'h10, 8'h3C);
    expect_txn(1, 1'b1, 6'h11, 8'hC3);
    wait_drain(40);
    n_cmp++;
    if (last_ack[1] - last_ack[0] != 3) begin
      n_bad++;
      $display("FAIL simul_gap b_minus_a=%0d required 3", last_ack[1] - last_ack[0]);
    end
  endtask

  task automatic test_fairness;
    for (int i = 0; i < 3; i++) begin
      expect_txn(0, (i != 2), 6'(6'h20 + i), 8'(8'h40 + i));
      expect_txn(1, (i == 0), 6'(6'h21 + i), 8'(8'h90 + i));
    end
    wait_drain(80);
    n_cmp++;
    if (last_ack[1] - last_ack[0] != 3) begin
      n_bad++;
      $display("FAIL fair_gap b_minus_a=%0d required 3", last_ack[1] - last_ack[0]);
    end
  endtask

  task automatic test_b_only_then_priority;
    expect_txn(1, 1'b1, 6'h30, 8'h77);
    expect_txn(1, 1'b0, 6'h30, 8'h00);
    wait_drain(40);
    // Two B grants leave priority at A, so A wins the next tie.
    expect_txn(0, 1'b0, 6'h30, 8'h00);
    expect_txn(1, 1'b0, 6'h05, 8'h00);
    wait_drain(40);
    n_cmp++;
    if (last_ack[1] - last_ack[0] != 3) begin
      n_bad++;
      $display("FAIL prio_after_b b_minus_a=%0d required 3", last_ack[1] - last_ack[0]);
    end
  endtask

  task automatic test_reset_in_resp;
    txn_t t;
    int w;
    t.we = 1'b0; t.addr = 6'h05; t.wdata = '0;
    txq_a.push_back(t);
    w = 0;
    while (req_v[0] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack_v !== 2'b00) begin
      n_bad++;
      $display("FAIL resp_reset_ack ack=%b required 00", ack_v);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ack_v !== 2'b00 || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL resp_reset_after busy=%b ack=%b we=%b required 0/00/0", busy, ack_v, ram_we);
    end
  endtask

  initial begin : main
    test_reset();
    test_idle();
    test_single_write_read();
    test_simultaneous();
    test_fairness();
    test_b_only_then_priority();
    test_reset_in_resp();
    test_idle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expect count=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
